ps2_scancode_ctrl: RTL and testbench

//   Sequencer between the PS/2 byte receiver and the application. Consumes raw
//   Set-2 scan-code bytes (byte + finish strobe) and tracks E0/F0/E1 prefix

---
 rtl/ps2_scancode_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ps2_scancode_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scan-code sequencer: tracks E0/F0/E1 prefixes, builds
// {ext,break,code} key events and queues them in a small FWFT FIFO.
// Ports: i_clk, i_rst_n (async low); i_byte/i_byte_done from receiver;
// o_key_code/o_key_ext/o_key_break/o_key_valid, i_key_ready consumer side;
// i_clr_err clears sticky o_err[2:0] = {bad byte, prefix timeout, overflow}.
module ps2_scancode_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_byte_done,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_break,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  input  logic       i_clr_err,
  output logic [2:0] o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   tmo_q;
  logic            done_q;
  logic            take;
  logic            tmo_hit;
  logic            push;
  logic [9:0]      push_ev;
  logic            bad;

  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            pop, full, wr_en, ovf;
  logic [2:0]      err_q;

  logic is_e0, is_f0, is_e1, is_bad, is_ign;

  assign take    = i_byte_done & ~done_q;
  assign is_e0   = (i_byte == 8'hE0);
  assign is_f0   = (i_byte == 8'hF0);
  assign is_e1   = (i_byte == 8'hE1);
  assign is_bad  = (i_byte == 8'h00) || (i_byte == 8'hFF);
  assign is_ign  = (i_byte == 8'hAA) || (i_byte == 8'hFA) ||
                   (i_byte == 8'hFE) || (i_byte == 8'hEE);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit = (state_q != S_IDLE) && !take &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      done_q  <= i_byte_done;
      if (take || tmo_hit || state_q == S_IDLE)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    push    = 1'b0;
    push_ev = '0;
    bad     = 1'b0;
    if (take) begin
      case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            is_e0:  state_d = S_EXT;
            is_f0:  state_d = S_BRK;
            is_e1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            is_bad: bad = 1'b1;
            is_ign: ;
            default: begin
              push    = 1'b1;
              push_ev = {2'b00, i_byte};
            end
          endcase
        end
        S_EXT: begin
          if (is_f0) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
            bad     = is_bad;
            push    = !is_bad;
            push_ev = {2'b10, i_byte};
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          bad     = is_bad;
          push    = !is_bad;
          push_ev = {2'b01, i_byte};
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          bad     = is_bad;
          push    = !is_bad;
          push_ev = {2'b11, i_byte};
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          // Pause sends 8 bytes; report it once as make of E1.
          if (skip_q == 3'd1) begin
            state_d = S_IDLE;
            push    = 1'b1;
            push_ev = {2'b00, 8'hE1};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
      skip_d  = '0;
    end
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign pop   = (count_q != '0) && i_key_ready;
  assign wr_en = push && (!full || pop);
  assign ovf   = push && full && !pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_ev;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      err_q <= (i_clr_err ? 3'b000 : err_q) | {bad, tmo_hit, ovf};
    end
  end

  assign {o_key_ext, o_key_break, o_key_code} = mem_q[rd_ptr_q];
  assign o_key_valid = (count_q != '0);
  assign o_err       = err_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed bench for ps2_scancode_ctrl.
// Drives scan-code byte strobes, checks events/errors with assertions.
module tb_ps2_scancode_ctrl;

  localparam int TMO = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_done;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ready;
  logic       clr_err;
  logic [2:0] err;

  int checks = 0;
  int errors = 0;

  ps2_scancode_ctrl #(.DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_byte      (byte_in),
    .i_byte_done (byte_done),
    .o_key_code  (key_code),
    .o_key_ext   (key_ext),
    .o_key_break (key_break),
    .o_key_valid (key_valid),
    .i_key_ready (key_ready),
    .i_clr_err   (clr_err),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    byte_in   = b;
    byte_done = 1'b1;
    repeat (hold) @(negedge clk);
    byte_done = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ev(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    chk({tag, "_ev"}, 32'({key_ext, key_break, key_code}), 32'(exp));
  endtask

  task automatic clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  logic [7:0] seq [8];
  logic [7:0] mk  [5];

  initial begin
    rst_n     = 1'b0;
    byte_in   = 8'h00;
    byte_done = 1'b0;
    key_ready = 1'b1;
    clr_err   = 1'b0;
    gap(3);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_fields", 32'({key_ext, key_break, key_code}), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    gap(2);

    // 1: plain make, then break with long byte gap
    send(8'h1C, 1);
    chk_ev("t1_make", {2'b00, 8'h1C});
    gap(1);
    chk("t1_popped", 32'(key_valid), 0);
    send(8'hF0, 1);
    chk("t1_f0_none", 32'(key_valid), 0);
    gap(2000);
    send(8'h1C, 1);
    chk_ev("t1_brk", {2'b01, 8'h1C});
    gap(2);

    // 2: extended make and extended break
    send(8'hE0, 1);
    chk("t2_e0_none", 32'(key_valid), 0);
    gap(3);
    send(8'h75, 1);
    chk_ev("t2_ext", {2'b10, 8'h75});
    gap(2);
    send(8'hE0, 1);
    gap(2);
    send(8'hF0, 1);
    chk("t2_f0_none", 32'(key_valid), 0);
    gap(2);
    send(8'h75, 1);
    chk_ev("t2_extbrk", {2'b11, 8'h75});
    gap(2);
    chk("t2_err", 32'(err), 0);

    // 3: overflow with consumer stalled
    key_ready = 1'b0;
    mk = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
    for (int i = 0; i < 5; i++) begin
      send(mk[i], 1);
      gap(2);
    end
    chk("t3_err", 32'(err), 32'b001);
    chk_ev("t3_hold", {2'b00, 8'h15});
    @(negedge clk);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ev($sformatf("t3_drain%0d", i), {2'b00, mk[i]});
      @(negedge clk);
    end
    chk("t3_empty", 32'(key_valid), 0);
    clr();
    chk("t3_clr", 32'(err), 0);

    // 4: prefix timeout
    send(8'hE0, 1);
    gap(TMO / 2);
    chk("t4_no_tmo_yet", 32'(err), 0);
    gap(TMO / 2 + 10);
    chk("t4_tmo", 32'(err), 32'b010);
    chk("t4_none", 32'(key_valid), 0);
    send(8'h1C, 1);
    chk_ev("t4_after", {2'b00, 8'h1C});
    clr();
    chk("t4_clr", 32'(err), 0);

    // 5: pause sequence, bad byte, long strobe
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) begin
      send(seq[i], 1);
      chk($sformatf("t5_skip%0d", i), 32'(key_valid), 0);
      gap(2);
    end
    send(seq[7], 1);
    chk_ev("t5_pause", {2'b00, 8'hE1});
    gap(1);
    chk("t5_once", 32'(key_valid), 0);
    send(8'h00, 1);
    chk("t5_bad_err", 32'(err), 32'b100);
    chk("t5_bad_none", 32'(key_valid), 0);
    clr();
    key_ready = 1'b0;
    send(8'h1C, 5);
    chk_ev("t5_hold5", {2'b00, 8'h1C});
    key_ready = 1'b1;
    @(negedge clk);
    chk("t5_single", 32'(key_valid), 0);
    chk("t5_err", 32'(err), 0);

    // 6: reset mid-sequence, then full FIFO push+pop
    send(8'hF0, 1);
    gap(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(key_valid), 0);
    chk("t6_rst_err", 32'(err), 0);
    rst_n = 1'b1;
    gap(2);
    send(8'h1C, 1);
    chk_ev("t6_after_rst", {2'b00, 8'h1C});
    gap(2);
    key_ready = 1'b0;
    mk = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h29};
    for (int i = 0; i < 4; i++) begin
      send(mk[i], 1);
      gap(2);
    end
    chk("t6_full", 32'(dut.count_q), 4);
    @(negedge clk);
    key_ready = 1'b1;
    byte_in   = 8'h29;
    byte_done = 1'b1;
    @(negedge clk);
    byte_done = 1'b0;
    key_ready = 1'b0;
    chk("t6_cnt", 32'(dut.count_q), 4);
    chk("t6_no_ovf", 32'(err), 0);
    @(negedge clk);
    key_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk_ev($sformatf("t6_drain%0d", i), {2'b00, mk[i]});
      @(negedge clk);
    end
    chk("t6_empty", 32'(key_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
